// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite initiator: response codes, FSM states and default widths.
package axi_lite_pkg;

    localparam int ADDR_W_DEF         = 32;
    localparam int DATA_W_DEF         = 64;
    localparam int TIMEOUT_CYCLES_DEF = 256;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B,
        RESP
    } mst_state_e;

endpackage

// File: rtl/axi_lite_mst_wdog.sv
// Watchdog for axi_lite_mst: counts cycles spent in one busy state and flags expiry.
// Only instantiated when AXI_LITE_MST_TIMEOUT_EN is defined.
module axi_lite_mst_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic aclk,
    input  logic areset,
    input  logic clear,
    input  logic busy,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] count;

    // The count holds the number of completed cycles already spent in the current state.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count <= '0;
        end else if (clear || !busy) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = busy && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_mst.sv
// AXI-lite initiator: turns a single-outstanding core request/response port into AR/R/AW/W/B traffic.
// Optional watchdog timeout enabled by defining AXI_LITE_MST_TIMEOUT_EN.
module axi_lite_mst
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    mst_state_e state, state_d;

    logic                req_ready_d, resp_valid_d, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_d, wdata_d;
    logic [ADDR_W-1:0]   araddr_d, awaddr_d;
    logic [DATA_W/8-1:0] wstrb_d;
    logic                arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
    logic                timeout_hit;

`ifdef AXI_LITE_MST_TIMEOUT_EN
    logic busy;

    assign busy = (state == RD_A) || (state == RD_D) || (state == WR_AW) || (state == WR_B);

    axi_lite_mst_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .aclk    (aclk),
        .areset  (areset),
        .clear   (state_d != state),
        .busy    (busy),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d      = state;
        req_ready_d  = req_ready;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        araddr_d     = araddr;
        arvalid_d    = arvalid;
        rready_d     = rready;
        awaddr_d     = awaddr;
        awvalid_d    = awvalid;
        wdata_d      = wdata;
        wstrb_d      = wstrb;
        wvalid_d     = wvalid;
        bready_d     = bready;

        case (state)
            IDLE: begin
                req_ready_d = 1'b1;
`ifdef AXI_LITE_MST_TIMEOUT_EN
                rready_d = 1'b1;
                bready_d = 1'b1;
`endif
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    rready_d    = 1'b0;
                    bready_d    = 1'b0;
                    if (req_wen) begin
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW;
                    end else begin
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_A;
                    end
                end
            end
            RD_A: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end
            end
            RD_D: begin
                if (rvalid) begin
                    resp_rdata_d = rdata;
                    resp_err_d   = (rresp != OKAY);
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            WR_AW: begin
                // A valid already low means its handshake happened in an earlier cycle.
                awvalid_d = awvalid && !awready;
                wvalid_d  = wvalid && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (bvalid) begin
                    resp_rdata_d = '0;
                    resp_err_d   = (bresp != OKAY);
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
`ifdef AXI_LITE_MST_TIMEOUT_EN
                    rready_d = 1'b1;
                    bready_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        if (timeout_hit) begin
            arvalid_d    = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            rready_d     = 1'b0;
            bready_d     = 1'b0;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= '0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            state      <= state_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            araddr     <= araddr_d;
            arvalid    <= arvalid_d;
            rready     <= rready_d;
            awaddr     <= awaddr_d;
            awvalid    <= awvalid_d;
            wdata      <= wdata_d;
            wstrb      <= wstrb_d;
            wvalid     <= wvalid_d;
            bready     <= bready_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_mst.sv
// Self-checking bench for axi_lite_mst with a cycle-level AXI-lite responder and a latency/response model.
// Timeout scenario is compiled only when AXI_LITE_MST_TIMEOUT_EN is defined.
module tb_axi_lite_mst;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int TIMEOUT    = 8;
    localparam int TXN_BUDGET = 300;

    logic                aclk, areset;
    logic                req_valid, req_ready, req_wen;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic                resp_valid, resp_ready, resp_err;
    logic [DATA_W-1:0]   resp_rdata;
    logic [ADDR_W-1:0]   araddr, awaddr;
    logic                arvalid, arready, rvalid, rready;
    logic [DATA_W-1:0]   rdata, wdata;
    logic [1:0]          rresp, bresp;
    logic                awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DATA_W/8-1:0] wstrb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               resp_cyc, ar_cyc, r_cyc, aw_cyc, w_cyc, b_cyc;
        int               aw_high, w_high;
        logic [DATA_W-1:0] rdata;
        logic             err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W/8-1:0] wstrb;
        int               rready_gaps, bready_gaps, viol, req_ready_busy;
        bit               timed_out;
        logic             req_ready_after;
    } obs_t;

    axi_lite_mst #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] global timeout");
    end

    // Reference timing: first response cycle counted from the request-accept cycle (cycle 0).
    function automatic int exp_latency(bit wen, int ar_d, int r_d, int aw_d, int w_d, int b_d);
        if (wen) return 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
        return 3 + ar_d + r_d;
    endfunction

    // Drives one request and plays a responder with the given per-channel delays; returns observations.
    task automatic run_txn(input bit wen, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                           input logic [DATA_W/8-1:0] ws, input int ar_d, input int r_d, input int aw_d,
                           input int w_d, input int b_d, input int resp_d, input logic [DATA_W-1:0] rd,
                           input logic [1:0] rsp, input bit issued, input bit hold_next,
                           input logic [ADDR_W-1:0] next_addr, output obs_t o);
        bit done;
        bit ar_seen, aw_seen, w_seen;
        int ar_cnt, aw_cnt, w_cnt, resp_cnt, last;
        logic [ADDR_W-1:0] a0, aw0;
        logic [DATA_W-1:0] w0;
        logic [DATA_W/8-1:0] s0;
        o = '{default: 0};
        o.resp_cyc = -1; o.ar_cyc = -1; o.r_cyc = -1; o.aw_cyc = -1; o.w_cyc = -1; o.b_cyc = -1;
        done = 0; ar_seen = 0; aw_seen = 0; w_seen = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; resp_cnt = 0;
        a0 = '0; aw0 = '0; w0 = '0; s0 = '0;
        if (!issued) begin
            @(negedge aclk);
            req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws;
            if (req_ready !== 1'b1) o.viol++;
        end
        for (int c = 1; c <= TXN_BUDGET && !done; c++) begin
            @(negedge aclk);
            if (c == 1) req_valid = 1'b0;
            if (req_ready !== 1'b0) o.req_ready_busy++;
            arready = 1'b0;
            if (arvalid === 1'b1) begin
                if (!ar_seen) begin ar_seen = 1; a0 = araddr; end
                else if (araddr !== a0) o.viol++;
                if (ar_cnt >= ar_d) begin arready = 1'b1; o.ar_cyc = c; o.addr = araddr; end
                ar_cnt++;
            end
            rvalid = 1'b0;
            if (o.ar_cyc >= 0 && o.ar_cyc < c && o.r_cyc < 0) begin
                if (rready !== 1'b1) o.rready_gaps++;
                if (c - o.ar_cyc - 1 >= r_d) begin
                    rvalid = 1'b1; rdata = rd; rresp = rsp;
                    if (rready === 1'b1) o.r_cyc = c;
                end
            end
            awready = 1'b0;
            if (awvalid === 1'b1) begin
                o.aw_high++;
                if (!aw_seen) begin aw_seen = 1; aw0 = awaddr; end
                else if (awaddr !== aw0) o.viol++;
                if (aw_cnt >= aw_d) begin awready = 1'b1; o.aw_cyc = c; o.addr = awaddr; end
                aw_cnt++;
            end
            wready = 1'b0;
            if (wvalid === 1'b1) begin
                o.w_high++;
                if (!w_seen) begin w_seen = 1; w0 = wdata; s0 = wstrb; end
                else if (wdata !== w0 || wstrb !== s0) o.viol++;
                if (w_cnt >= w_d) begin wready = 1'b1; o.w_cyc = c; o.wdata = wdata; o.wstrb = wstrb; end
                w_cnt++;
            end
            bvalid = 1'b0;
            if (o.aw_cyc >= 0 && o.w_cyc >= 0 && o.aw_cyc < c && o.w_cyc < c && o.b_cyc < 0) begin
                last = (o.aw_cyc > o.w_cyc) ? o.aw_cyc : o.w_cyc;
                if (bready !== 1'b1) o.bready_gaps++;
                if (c - last - 1 >= b_d) begin
                    bvalid = 1'b1; bresp = rsp;
                    if (bready === 1'b1) o.b_cyc = c;
                end
            end
            resp_ready = 1'b0;
            if (resp_valid === 1'b1) begin
                if (o.resp_cyc < 0) begin o.resp_cyc = c; o.rdata = resp_rdata; o.err = resp_err; end
                else if (resp_rdata !== o.rdata || resp_err !== o.err) o.viol++;
                if (hold_next) begin req_valid = 1'b1; req_wen = 1'b0; req_addr = next_addr; end
                if (resp_cnt >= resp_d) begin resp_ready = 1'b1; done = 1; end
                resp_cnt++;
            end
        end
        if (!done) o.timed_out = 1;
        @(negedge aclk);
        resp_ready = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
        o.req_ready_after = req_ready;
        if (!hold_next) req_valid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b0;
        #1 areset = 1'b1;
        #2;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                     {resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready});
        end
        checks++;
        if ({resp_rdata, araddr, awaddr, wdata, wstrb} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got rdata=%h araddr=%h awaddr=%h wdata=%h wstrb=%h expected 0",
                     resp_rdata, araddr, awaddr, wdata, wstrb);
        end
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_read_basic();
        obs_t o;
        run_txn(1'b0, 32'h0000_2040, '0, '0, 0, 0, 0, 0, 0, 0, 64'hDEAD_BEEF_0123_4567, 2'b00,
                1'b0, 1'b0, '0, o);
        checks++;
        if (o.resp_cyc !== 3) begin
            errors++; $display("[TB] FAIL read_latency: got %0d expected 3", o.resp_cyc);
        end
        checks++;
        if (o.rdata !== 64'hDEAD_BEEF_0123_4567 || o.err !== 1'b0) begin
            errors++; $display("[TB] FAIL read_data: got %h err=%b expected deadbeef01234567 err=0", o.rdata, o.err);
        end
        checks++;
        if (o.addr !== 32'h0000_2040 || o.viol != 0 || o.req_ready_busy != 0) begin
            errors++;
            $display("[TB] FAIL read_addr: got addr=%h viol=%0d busy_ready=%0d expected 00002040 0 0",
                     o.addr, o.viol, o.req_ready_busy);
        end
    endtask

    task automatic test_write_skew();
        obs_t o;
        run_txn(1'b1, 32'h0000_1000, 64'h1122_3344_5566_7788, 8'h0F, 0, 0, 0, 3, 0, 0, '0, 2'b00,
                1'b0, 1'b0, '0, o);
        checks++;
        if (o.aw_cyc !== 1 || o.w_cyc !== 4 || o.aw_high !== 1 || o.w_high !== 4) begin
            errors++;
            $display("[TB] FAIL write_skew_order: got aw=%0d w=%0d aw_high=%0d w_high=%0d expected 1 4 1 4",
                     o.aw_cyc, o.w_cyc, o.aw_high, o.w_high);
        end
        checks++;
        if (o.resp_cyc !== exp_latency(1, 0, 0, 0, 3, 0) || o.b_cyc !== 5 || o.bready_gaps !== 0) begin
            errors++;
            $display("[TB] FAIL write_skew_latency: got resp=%0d b=%0d gaps=%0d expected %0d 5 0",
                     o.resp_cyc, o.b_cyc, o.bready_gaps, exp_latency(1, 0, 0, 0, 3, 0));
        end
        checks++;
        if (o.wdata !== 64'h1122_3344_5566_7788 || o.wstrb !== 8'h0F || o.addr !== 32'h0000_1000) begin
            errors++;
            $display("[TB] FAIL write_skew_payload: got %h/%h/%h expected 1122334455667788/0f/00001000",
                     o.wdata, o.wstrb, o.addr);
        end
        checks++;
        if (o.rdata !== '0 || o.err !== 1'b0 || o.viol !== 0) begin
            errors++; $display("[TB] FAIL write_skew_resp: got rdata=%h err=%b viol=%0d expected 0 0 0",
                               o.rdata, o.err, o.viol);
        end
    endtask

    task automatic test_read_err();
        obs_t o;
        run_txn(1'b0, 32'h0000_3008, '0, '0, 0, 5, 0, 0, 0, 0, 64'h0BAD_F00D_0000_0001, 2'b10,
                1'b0, 1'b0, '0, o);
        checks++;
        if (o.rready_gaps !== 0 || o.r_cyc !== 7) begin
            errors++; $display("[TB] FAIL read_err_rready: got gaps=%0d r_cyc=%0d expected 0 7",
                               o.rready_gaps, o.r_cyc);
        end
        checks++;
        if (o.err !== 1'b1 || o.rdata !== 64'h0BAD_F00D_0000_0001 || o.resp_cyc !== exp_latency(0, 0, 5, 0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL read_err_resp: got err=%b rdata=%h cyc=%0d expected 1 0badf00d00000001 %0d",
                     o.err, o.rdata, o.resp_cyc, exp_latency(0, 0, 5, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, o2;
        run_txn(1'b0, 32'h0000_4000, '0, '0, 0, 0, 0, 0, 0, 4, 64'h5555_AAAA_5555_AAAA, 2'b00,
                1'b0, 1'b1, 32'h0000_4100, o);
        checks++;
        if (o.viol !== 0 || o.req_ready_busy !== 0 || o.rdata !== 64'h5555_AAAA_5555_AAAA) begin
            errors++;
            $display("[TB] FAIL b2b_hold: got viol=%0d busy_ready=%0d rdata=%h expected 0 0 5555aaaa5555aaaa",
                     o.viol, o.req_ready_busy, o.rdata);
        end
        checks++;
        if (o.req_ready_after !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_ready_after: got %b expected 1", o.req_ready_after);
        end
        run_txn(1'b0, '0, '0, '0, 0, 0, 0, 0, 0, 0, 64'h0000_0000_CAFE_0001, 2'b00,
                1'b1, 1'b0, '0, o2);
        checks++;
        if (o2.addr !== 32'h0000_4100 || o2.resp_cyc !== 3 || o2.rdata !== 64'h0000_0000_CAFE_0001) begin
            errors++;
            $display("[TB] FAIL b2b_second: got addr=%h cyc=%0d rdata=%h expected 00004100 3 00000000cafe0001",
                     o2.addr, o2.resp_cyc, o2.rdata);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(negedge aclk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0000_5000;
        req_wdata = 64'hFFFF_0000_FFFF_0000; req_wstrb = 8'hFF;
        @(negedge aclk);
        req_valid = 1'b0;
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_pre: got aw=%b w=%b expected 1 1", awvalid, wvalid);
        end
        #2 areset = 1'b1;
        #1;
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, resp_valid, req_ready} !== 7'b0000001) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got %b expected 0000001",
                     {arvalid, awvalid, wvalid, rready, bready, resp_valid, req_ready});
        end
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || awvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_release: got ready=%b resp=%b aw=%b expected 1 0 0",
                               req_ready, resp_valid, awvalid);
        end
        run_txn(1'b0, 32'h0000_5008, '0, '0, 1, 1, 0, 0, 0, 0, 64'h1357_9BDF_2468_ACE0, 2'b00,
                1'b0, 1'b0, '0, o);
        checks++;
        if (o.rdata !== 64'h1357_9BDF_2468_ACE0 || o.err !== 1'b0 || o.resp_cyc !== exp_latency(0, 1, 1, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL rstmid_read: got rdata=%h err=%b cyc=%0d expected 13579bdf2468ace0 0 %0d",
                               o.rdata, o.err, o.resp_cyc, exp_latency(0, 1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_stray();
        int bad;
        obs_t o;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            rvalid = 1'b1; bvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF; rresp = 2'b11; bresp = 2'b11;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || arvalid !== 1'b0 || awvalid !== 1'b0) bad++;
        end
        @(negedge aclk);
        rvalid = 1'b0; bvalid = 1'b0;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("[TB] FAIL stray_idle: got %0d bad cycles expected 0", bad);
        end
        run_txn(1'b1, 32'h0000_6000, 64'h0, 8'h00, 0, 0, 1, 0, 0, 0, '0, 2'b00, 1'b0, 1'b0, '0, o);
        checks++;
        if (o.wstrb !== 8'h00 || o.err !== 1'b0 || o.resp_cyc !== exp_latency(1, 0, 0, 1, 0, 0)) begin
            errors++; $display("[TB] FAIL stray_then_write: got strb=%h err=%b cyc=%0d expected 00 0 %0d",
                               o.wstrb, o.err, o.resp_cyc, exp_latency(1, 0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_random();
        obs_t o;
        bit wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd, rd;
        logic [DATA_W/8-1:0] ws;
        logic [1:0] rsp;
        int ar_d, r_d, aw_d, w_d, b_d, rs_d, lat;
        for (int i = 0; i < 12; i++) begin
            wen  = 1'($urandom_range(0, 1));
            addr = {$urandom()} & 32'hFFFF_FFF8;
            wd   = {$urandom(), $urandom()};
            rd   = {$urandom(), $urandom()};
            ws   = 8'($urandom());
            rsp  = 2'($urandom());
            ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
            aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3);
            b_d  = $urandom_range(0, 3); rs_d = $urandom_range(0, 2);
            run_txn(wen, addr, wd, ws, ar_d, r_d, aw_d, w_d, b_d, rs_d, rd, rsp, 1'b0, 1'b0, '0, o);
            lat = exp_latency(wen, ar_d, r_d, aw_d, w_d, b_d);
            checks++;
            if (o.timed_out || o.resp_cyc !== lat) begin
                errors++; $display("[TB] FAIL rand%0d_latency: got %0d (hung=%0d) expected %0d",
                                   i, o.resp_cyc, o.timed_out, lat);
            end
            checks++;
            if (o.rdata !== (wen ? 64'h0 : rd) || o.err !== (rsp != 2'b00)) begin
                errors++; $display("[TB] FAIL rand%0d_resp: got %h err=%b expected %h err=%b",
                                   i, o.rdata, o.err, wen ? 64'h0 : rd, rsp != 2'b00);
            end
            checks++;
            if (o.addr !== addr || (wen && (o.wdata !== wd || o.wstrb !== ws)) || o.viol !== 0) begin
                errors++; $display("[TB] FAIL rand%0d_payload: got %h/%h/%h viol=%0d expected %h/%h/%h 0",
                                   i, o.addr, o.wdata, o.wstrb, o.viol, addr, wd, ws);
            end
        end
    endtask

`ifdef AXI_LITE_MST_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        int bad;
        run_txn(1'b0, 32'h0000_7000, '0, '0, 100000, 0, 0, 0, 0, 0, 64'h1, 2'b00, 1'b0, 1'b0, '0, o);
        checks++;
        if (o.timed_out || o.resp_cyc !== 1 + TIMEOUT || o.err !== 1'b1 || o.rdata !== '0) begin
            errors++; $display("[TB] FAIL timeout_resp: got cyc=%0d err=%b rdata=%h expected %0d 1 0",
                               o.resp_cyc, o.err, o.rdata, 1 + TIMEOUT);
        end
        bad = 0;
        @(negedge aclk);
        rvalid = 1'b1; rdata = 64'hAAAA; rresp = 2'b00;
        if (rready !== 1'b1) bad++;
        @(negedge aclk);
        rvalid = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("[TB] FAIL timeout_drain: got %0d bad cycles expected 0", bad);
        end
    endtask
`endif

    initial begin
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0; arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        test_reset();
        test_read_basic();
        test_write_skew();
        test_read_err();
        test_back_to_back();
        test_reset_mid();
        test_stray();
        test_random();
`ifdef AXI_LITE_MST_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
